// File: rtl/rsa_modexp.sv
// Modular exponentiation engine: left-to-right square-and-multiply over an
// interleaved MSB-first modular multiplier that retires one multiplier bit per clock.
module rsa_modexp #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    IDX_MAX  = IW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]    IDX_ZERO = {IW{1'b0}};
    localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] VAL_TWO  = {{(WIDTH-2){1'b0}}, 2'b10};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        SQUARE = 3'd2,
        MULT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
    logic [WIDTH-1:0] acc_q, acc_d, r_q, r_d, result_q, result_d;
    logic [IW-1:0]    bit_q, bit_d, cnt_q, cnt_d;
    logic             illegal_q, illegal_d, busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic             illegal_s, exp_bit_s, bit_zero_s, mul_last_s, mul_a_s;
    logic [WIDTH-1:0] mul_b_s, step_s;

    // r < m on entry, so 2r + b < 3m fits in WIDTH+2 bits and two subtractions restore r < m.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] r,
        input logic             a_bit,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] mx;
        mx = {2'b00, m};
        t  = {1'b0, r, 1'b0} + (a_bit ? {2'b00, b} : {(WIDTH+2){1'b0}});
        t  = (t >= mx) ? (t - mx) : t;
        t  = (t >= mx) ? (t - mx) : t;
        return t[WIDTH-1:0];
    endfunction

    assign illegal_s  = (modulus < VAL_TWO) || (base >= modulus);
    assign exp_bit_s  = exp_q[bit_q];
    assign bit_zero_s = (bit_q == IDX_ZERO);
    assign mul_last_s = (cnt_q == IDX_ZERO);
    assign mul_a_s    = acc_q[cnt_q];
    assign mul_b_s    = (state_q == MULT) ? base_q : acc_q;
    assign step_s     = mod_step(r_q, mul_a_s, mul_b_s, mod_q);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = illegal_s ? FINISH : SCAN;
                else       state_d = IDLE;
            end
            SCAN: begin
                if (exp_bit_s)       state_d = bit_zero_s ? FINISH : SQUARE;
                else if (bit_zero_s) state_d = FINISH;
                else                 state_d = SCAN;
            end
            SQUARE: begin
                if (!mul_last_s)     state_d = SQUARE;
                else if (exp_bit_s)  state_d = MULT;
                else if (bit_zero_s) state_d = FINISH;
                else                 state_d = SQUARE;
            end
            MULT: begin
                if (!mul_last_s)     state_d = MULT;
                else if (bit_zero_s) state_d = FINISH;
                else                 state_d = SQUARE;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, exponent scan and the bit-serial multiply.
    always_comb begin
        base_d    = base_q;
        exp_d     = exp_q;
        mod_d     = mod_q;
        acc_d     = acc_q;
        r_d       = r_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = base;
                    exp_d     = exponent;
                    mod_d     = modulus;
                    acc_d     = VAL_ZERO;
                    r_d       = VAL_ZERO;
                    bit_d     = IDX_MAX;
                    cnt_d     = IDX_MAX;
                    illegal_d = illegal_s;
                end else begin
                    illegal_d = illegal_q;
                end
            end
            SCAN: begin
                if (exp_bit_s)       acc_d = base_q;
                else if (bit_zero_s) acc_d = VAL_ONE;
                else                 acc_d = acc_q;
                bit_d = bit_zero_s ? bit_q : (bit_q - IDX_ONE);
            end
            SQUARE, MULT: begin
                if (mul_last_s) begin
                    acc_d = step_s;
                    r_d   = VAL_ZERO;
                    cnt_d = IDX_MAX;
                    // A square on a set bit keeps the index so MULT sees the same bit.
                    if ((state_q == SQUARE) && exp_bit_s) bit_d = bit_q;
                    else if (bit_zero_s)                  bit_d = bit_q;
                    else                                  bit_d = bit_q - IDX_ONE;
                end else begin
                    r_d   = step_s;
                    cnt_d = cnt_q - IDX_ONE;
                end
            end
            FINISH:  acc_d = acc_q;
            default: acc_d = acc_q;
        endcase
    end

    // Registered output decode; busy spans the done cycle after leaving FINISH.
    always_comb begin
        busy_d   = (state_d != IDLE) || (state_q == FINISH);
        done_d   = (state_q == FINISH);
        error_d  = (state_q == FINISH) && illegal_q;
        if (state_q == FINISH) result_d = acc_q;
        else                   result_d = result_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= VAL_ZERO;
            exp_q     <= VAL_ZERO;
            mod_q     <= VAL_ZERO;
            acc_q     <= VAL_ZERO;
            r_q       <= VAL_ZERO;
            bit_q     <= IDX_ZERO;
            cnt_q     <= IDX_ZERO;
            illegal_q <= 1'b0;
            result_q  <= VAL_ZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            base_q    <= base_d;
            exp_q     <= exp_d;
            mod_q     <= mod_d;
            acc_q     <= acc_d;
            r_q       <= r_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: directed vectors, randomized operands
// against an arithmetic reference, and multi-cycle corner sequences.
module tb_rsa_modexp;

    localparam int W  = 16;
    localparam int W2 = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  base, exponent, modulus, result;
    logic          busy, done, error;
    logic          start2;
    logic [W2-1:0] base2, exponent2, modulus2, result2;
    logic          busy2, done2, error2;

    int total = 0;
    int bad   = 0;

    rsa_modexp #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
        .modulus(modulus), .result(result), .busy(busy), .done(done), .error(error)
    );

    rsa_modexp #(.WIDTH(W2)) dut128 (
        .clk(clk), .reset(reset), .start(start2), .base(base2), .exponent(exponent2),
        .modulus(modulus2), .result(result2), .busy(busy2), .done(done2), .error(error2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic [W-1:0] m;
        logic [W-1:0] r;
        int           lat;
        logic         err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain right-to-left binary exponentiation in 64-bit arithmetic.
    function automatic longint unsigned ref_modexp(input longint unsigned b, input longint unsigned e,
                                                   input longint unsigned m);
        longint unsigned r, x, k;
        if (m < 2 || b >= m) return 0;
        r = 1; x = b; k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % m;
            x = (x * x) % m;
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
        int p;
        if (m < 2 || b >= m) return 1;
        p = -1;
        for (int k = 0; k < W; k++) if (e[k]) p = k;
        if (p < 0) return 1 + W;
        return 1 + (W - p) + W * (p + $countones(e) - 1);
    endfunction

    // Issue one operation and wait (bounded) for done; lat=0 means it never came.
    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                          output logic [W-1:0] r, output int lat, output logic err);
        bit found;
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
        chk("busy_after_accept", 128'(busy), 128'd1);
        r = '0; lat = 0; err = 1'b0; found = 1'b0;
        for (int n = 1; n <= 4000 && !found; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1; lat = n; r = result; err = error;
            end
        end
    endtask

    initial begin
        logic [W-1:0] r, rb, rm, re;
        logic [127:0] one128, pow127;
        int           lat, n, dcount;
        logic         err, found;

        vecs[0] = '{16'd4,    16'd13,   16'd497,  16'd445,  94,  1'b0};
        vecs[1] = '{16'd65,   16'd17,   16'd3233, 16'd2790, 93,  1'b0};
        vecs[2] = '{16'd2790, 16'd2753, 16'd3233, 16'd65,   246, 1'b0};
        vecs[3] = '{16'd5,    16'd0,    16'd7,    16'd1,    17,  1'b0};
        vecs[4] = '{16'd0,    16'd5,    16'd1,    16'd0,    1,   1'b1};
        vecs[5] = '{16'd9,    16'd3,    16'd7,    16'd0,    1,   1'b1};

        reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
        start2 = 1'b0; base2 = '0; exponent2 = '0; modulus2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", 128'(result), 128'd0);
        chk("reset_busy",   128'(busy),   128'd0);
        chk("reset_done",   128'(done),   128'd0);
        chk("reset_error",  128'(error),  128'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].b, vecs[i].e, vecs[i].m, r, lat, err);
            chk($sformatf("vec%0d_result", i),  128'(r),   128'(vecs[i].r));
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
            chk($sformatf("vec%0d_error", i),   128'(err), 128'(vecs[i].err));
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", 128'(done),  128'd0);
        chk("busy_drops",     128'(busy),  128'd0);
        chk("error_one_cycle", 128'(error), 128'd0);

        for (int i = 0; i < 25; i++) begin
            rm = W'($urandom_range(2, 65535));
            rb = W'($urandom % rm);
            re = W'($urandom);
            if (i % 6 == 5) rb = rm + W'($urandom_range(0, 3));
            if (i % 6 == 5 && rb < rm) rb = rm;
            run_op(rb, re, rm, r, lat, err);
            chk($sformatf("rand%0d_result", i),  128'(r),   128'(ref_modexp(64'(rb), 64'(re), 64'(rm))));
            chk($sformatf("rand%0d_latency", i), 128'(lat), 128'(ref_latency(rb, re, rm)));
            chk($sformatf("rand%0d_error", i),   128'(err), 128'((rm < 2 || rb >= rm) ? 1 : 0));
        end

        // Start pulsed mid-run must be ignored and leave the held result untouched.
        run_op(16'd65, 16'd17, 16'd3233, r, lat, err);
        chk("pre_busy_result", 128'(r), 128'd2790);
        @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("held_result_mid_run", 128'(result), 128'd2790);
        chk("busy_mid_run",        128'(busy),   128'd1);
        @(negedge clk);
        base = 16'd2; exponent = 16'd3; modulus = 16'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 11; found = 1'b0;
        while (n < 400 && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (done) found = 1'b1;
        end
        chk("ignored_start_latency", 128'(found ? n : 0), 128'd94);
        chk("ignored_start_result",  128'(result),        128'd445);
        @(posedge clk);
        #1;
        chk("ignored_start_no_rerun", 128'(busy), 128'd0);

        // Reset at cycle 40 aborts with no done; the next run is normal.
        @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_result", 128'(result), 128'd0);
        chk("async_reset_busy",   128'(busy),   128'd0);
        dcount = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("aborted_no_done", 128'(dcount), 128'd0);
        run_op(16'd4, 16'd13, 16'd497, r, lat, err);
        chk("post_reset_result",  128'(r),   128'd445);
        chk("post_reset_latency", 128'(lat), 128'd94);

        // Wide instance: 2^127 mod (2^127 + 1).
        one128 = 128'd1;
        pow127 = one128 << 127;
        @(negedge clk);
        base2 = 128'd2; exponent2 = 128'd127; modulus2 = pow127 + one128; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0; found = 1'b0;
        while (n < 3000 && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (done2) found = 1'b1;
        end
        chk("w128_latency", 128'(found ? n : 0), 128'd1659);
        chk("w128_result",  result2,             pow127);
        chk("w128_error",   128'(error2),        128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
